// File: rtl/tt_matrix_seq.sv
// Matrix-unit instruction sequencer: decodes OPACC/CIN/COUT, reads the VRF, strobes the
// outer-product accumulator and returns COUT results to the load queue.
module tt_matrix_seq #(
  parameter int unsigned LQ_DEPTH_LOG2 = 3,
  parameter int unsigned NUM_MREGS     = 2,
  parameter int unsigned OPACC_LAT     = 2,
  localparam int unsigned MW = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_inst_vld,
  input  logic [31:0]              i_inst,
  input  logic [LQ_DEPTH_LOG2-1:0] i_lqid,
  output logic                     o_inst_rdy,
  input  logic                     i_lq_rdy,
  input  logic                     i_flush,
  output logic                     o_vrf_rd_vld,
  output logic [14:0]              o_vrf_rdaddr,
  output logic                     o_ab_valid,
  output logic                     o_ci_valid,
  output logic                     o_co_rd,
  output logic [MW-1:0]            o_mreg_addr,
  output logic                     o_lqvld,
  output logic [LQ_DEPTH_LOG2-1:0] o_lqid,
  output logic                     o_lqexc,
  output logic                     o_busy
);

  localparam int unsigned SBW        = $clog2(OPACC_LAT + 1);
  localparam int unsigned CW         = 3;
  localparam logic [6:0]  OPC_MATRIX = 7'h0B;

  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_EXEC, S_DRAIN, S_EXC} state_t;
  typedef enum logic [1:0] {OP_OPACC, OP_CIN, OP_COUT} op_t;

  state_t                   state_q;
  op_t                      op_q;
  logic [MW-1:0]            mreg_q;
  logic [14:0]              addr_q;
  logic [LQ_DEPTH_LOG2-1:0] lqid_q;
  logic [CW-1:0]            cnt_q;
  logic [SBW-1:0]           sb_q   [NUM_MREGS];
  logic [SBW-1:0]           sb_nxt [NUM_MREGS];
  logic                     sb_busy_nxt;

  logic [2:0]    f3_c;
  logic [MW-1:0] mreg_c;
  logic          illegal_c;
  op_t           dec_op_c;
  logic          unused_inst_c;

  assign f3_c          = i_inst[14:12];
  assign mreg_c        = i_inst[25 +: MW];
  assign unused_inst_c = ^i_inst[31:25+MW];

  // Decode of the offered instruction
  always_comb begin
    dec_op_c = OP_OPACC;
    if (f3_c == 3'd1)      dec_op_c = OP_CIN;
    else if (f3_c == 3'd2) dec_op_c = OP_COUT;
    illegal_c = (i_inst[6:0] != OPC_MATRIX) || (f3_c > 3'd2) || (32'(mreg_c) >= NUM_MREGS);
  end

  // Per-mreg hazard counters: reload on accumulate/move-in, count down otherwise
  always_comb begin
    sb_busy_nxt = 1'b0;
    for (int m = 0; m < NUM_MREGS; m++) begin
      sb_nxt[m] = (sb_q[m] != '0) ? sb_q[m] - SBW'(1) : '0;
      if (state_q == S_EXEC && op_q != OP_COUT && MW'(m) == mreg_q)
        sb_nxt[m] = SBW'(OPACC_LAT);
      sb_busy_nxt = sb_busy_nxt | (sb_nxt[m] != '0);
    end
  end

  // Sequencer FSM with registered strobes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_OPACC;
      mreg_q       <= '0;
      addr_q       <= '0;
      lqid_q       <= '0;
      cnt_q        <= '0;
      for (int m = 0; m < NUM_MREGS; m++) sb_q[m] <= '0;
      o_inst_rdy   <= 1'b1;
      o_vrf_rd_vld <= 1'b0;
      o_vrf_rdaddr <= '0;
      o_ab_valid   <= 1'b0;
      o_ci_valid   <= 1'b0;
      o_co_rd      <= 1'b0;
      o_mreg_addr  <= '0;
      o_lqvld      <= 1'b0;
      o_lqid       <= '0;
      o_lqexc      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      sb_q         <= sb_nxt;
      o_vrf_rd_vld <= 1'b0;
      o_ab_valid   <= 1'b0;
      o_ci_valid   <= 1'b0;
      o_co_rd      <= 1'b0;
      o_lqvld      <= 1'b0;
      o_lqexc      <= 1'b0;
      o_inst_rdy   <= 1'b0;
      o_busy       <= sb_busy_nxt;
      case (state_q)
        S_IDLE: begin
          o_inst_rdy <= 1'b1;
          if (i_inst_vld) begin
            op_q       <= dec_op_c;
            mreg_q     <= mreg_c;
            addr_q     <= {i_inst[19:15], i_inst[24:20], i_inst[11:7]};
            lqid_q     <= i_lqid;
            o_inst_rdy <= 1'b0;
            o_busy     <= 1'b1;
            state_q    <= illegal_c ? S_EXC : S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (i_flush) begin
            state_q    <= S_IDLE;
            o_inst_rdy <= 1'b1;
          end else if (op_q != OP_COUT || (sb_q[mreg_q] == '0 && i_lq_rdy)) begin
            o_vrf_rd_vld <= 1'b1;
            o_vrf_rdaddr <= addr_q;
            o_busy       <= 1'b1;
            state_q      <= S_EXEC;
          end else begin
            o_busy <= 1'b1;
          end
        end
        S_EXEC: begin
          o_mreg_addr <= mreg_q;
          case (op_q)
            OP_OPACC: begin
              o_ab_valid <= 1'b1;
              o_inst_rdy <= 1'b1;
              state_q    <= S_IDLE;
            end
            OP_CIN: begin
              o_ci_valid <= 1'b1;
              o_inst_rdy <= 1'b1;
              state_q    <= S_IDLE;
            end
            default: begin
              o_co_rd <= 1'b1;
              cnt_q   <= CW'(OPACC_LAT - 1);
              o_busy  <= 1'b1;
              state_q <= S_DRAIN;
            end
          endcase
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            o_lqvld    <= 1'b1;
            o_lqid     <= lqid_q;
            o_inst_rdy <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            o_busy <= 1'b1;
          end
        end
        S_EXC: begin
          o_lqvld    <= 1'b1;
          o_lqexc    <= 1'b1;
          o_lqid     <= lqid_q;
          o_inst_rdy <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          o_inst_rdy <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_matrix_seq.sv
// Bench for tt_matrix_seq: directed scenarios plus random traffic, checked every cycle
// against a transaction-level timeline model of the sequencer.
module tb_tt_matrix_seq;

  localparam int unsigned LQW  = 3;
  localparam int unsigned NM   = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MW   = (NM > 1) ? $clog2(NM) : 1;
  localparam int          MAXE = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inst_vld = 1'b0;
  logic [31:0]     inst = '0;
  logic [LQW-1:0]  lqid_in = '0;
  logic            lq_rdy = 1'b0;
  logic            flush = 1'b0;
  logic            inst_rdy, vrf_rd_vld, ab_valid, ci_valid, co_rd, lqvld, lqexc, busy;
  logic [14:0]     vrf_rdaddr;
  logic [MW-1:0]   mreg_addr;
  logic [LQW-1:0]  lqid_out;

  tt_matrix_seq #(.LQ_DEPTH_LOG2(LQW), .NUM_MREGS(NM), .OPACC_LAT(LAT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_inst_vld(inst_vld), .i_inst(inst), .i_lqid(lqid_in),
    .o_inst_rdy(inst_rdy), .i_lq_rdy(lq_rdy), .i_flush(flush), .o_vrf_rd_vld(vrf_rd_vld),
    .o_vrf_rdaddr(vrf_rdaddr), .o_ab_valid(ab_valid), .o_ci_valid(ci_valid), .o_co_rd(co_rd),
    .o_mreg_addr(mreg_addr), .o_lqvld(lqvld), .o_lqid(lqid_out), .o_lqexc(lqexc), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int e     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  // Expected output timeline, indexed by the clock edge after which each value is visible
  bit             exp_vrf [MAXE];
  bit             exp_ab  [MAXE];
  bit             exp_ci  [MAXE];
  bit             exp_co  [MAXE];
  bit             exp_lq  [MAXE];
  bit             exp_exc [MAXE];
  logic [14:0]    exp_addr[MAXE];
  logic [MW-1:0]  exp_mreg[MAXE];
  logic [LQW-1:0] exp_lqid[MAXE];

  typedef struct { int m; int at; } load_t;
  load_t loads[$];

  int             idle_edge = 0;
  bit             waiting = 1'b0;
  int             p_op, p_m;
  logic [14:0]    p_addr;
  logic [LQW-1:0] p_id;

  // Counter for mreg m (m < 0: any mreg) is nonzero after edge x
  function automatic bit sb_nz(input int m, input int x);
    foreach (loads[i])
      if ((m < 0 || loads[i].m == m) && loads[i].at <= x && x <= loads[i].at + int'(LAT) - 1)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] enc(input int f3, input int a, input int b, input int c,
                                      input int m);
    logic [31:0] w;
    w = '0;
    w[6:0]     = 7'h0B;
    w[11:7]    = 5'(c);
    w[14:12]   = 3'(f3);
    w[19:15]   = 5'(a);
    w[24:20]   = 5'(b);
    w[25 +: MW] = MW'(m);
    return w;
  endfunction

  task automatic step(input bit vld, input logic [31:0] w, input logic [LQW-1:0] id,
                      input bit lqr, input bit fl, input bit rst);
    logic [6:0] opc;
    int f3, m;
    bit rdy_exp, any_strobe;
    inst_vld = vld; inst = w; lqid_in = id; lq_rdy = lqr; flush = fl; rst_n = !rst;
    @(posedge clk);
    e++;
    if (rst) begin
      for (int k = e; k < MAXE; k++) begin
        exp_vrf[k] = 0; exp_ab[k] = 0; exp_ci[k] = 0; exp_co[k] = 0;
        exp_lq[k] = 0; exp_exc[k] = 0;
      end
      loads.delete();
      waiting   = 1'b0;
      idle_edge = e;
    end else if (!waiting && vld && e > idle_edge) begin
      opc = w[6:0];
      f3  = int'(w[14:12]);
      m   = int'(w[25 +: MW]);
      if (opc != 7'h0B || f3 > 2 || m >= int'(NM)) begin
        exp_lq[e+1] = 1; exp_exc[e+1] = 1; exp_lqid[e+1] = id;
        idle_edge   = e + 1;
      end else begin
        waiting = 1'b1; p_op = f3; p_m = m; p_id = id;
        p_addr  = {w[19:15], w[24:20], w[11:7]};
        idle_edge = 2 * MAXE;
      end
    end else if (waiting) begin
      if (fl) begin
        waiting   = 1'b0;
        idle_edge = e;
      end else if (p_op != 2 || (!sb_nz(p_m, e - 1) && lqr)) begin
        waiting       = 1'b0;
        exp_vrf[e]    = 1;
        exp_addr[e]   = p_addr;
        exp_mreg[e+1] = MW'(p_m);
        if (p_op == 0) exp_ab[e+1] = 1;
        else if (p_op == 1) exp_ci[e+1] = 1;
        else exp_co[e+1] = 1;
        if (p_op != 2) begin
          loads.push_back('{m: p_m, at: e + 1});
          idle_edge = e + 1;
        end else begin
          exp_lq[e+1+LAT]   = 1;
          exp_lqid[e+1+LAT] = p_id;
          idle_edge         = e + 1 + int'(LAT);
        end
      end
    end
    #1;
    rdy_exp    = (e >= idle_edge);
    any_strobe = exp_ab[e] | exp_ci[e] | exp_co[e];
    check_val("vrf_rd_vld", 32'(vrf_rd_vld), 32'(exp_vrf[e]));
    if (exp_vrf[e]) check_val("vrf_rdaddr", 32'(vrf_rdaddr), 32'(exp_addr[e]));
    check_val("ab_valid", 32'(ab_valid), 32'(exp_ab[e]));
    check_val("ci_valid", 32'(ci_valid), 32'(exp_ci[e]));
    check_val("co_rd", 32'(co_rd), 32'(exp_co[e]));
    if (any_strobe) check_val("mreg_addr", 32'(mreg_addr), 32'(exp_mreg[e]));
    check_val("lqvld", 32'(lqvld), 32'(exp_lq[e]));
    check_val("lqexc", 32'(lqexc), 32'(exp_exc[e]));
    if (exp_lq[e]) check_val("lqid", 32'(lqid_out), 32'(exp_lqid[e]));
    check_val("inst_rdy", 32'(inst_rdy), 32'(rdy_exp));
    check_val("busy", 32'(busy), 32'(!rdy_exp || sb_nz(-1, e)));
    if (rst) begin
      check_val("rst_lqid", 32'(lqid_out), 32'd0);
      check_val("rst_mreg_addr", 32'(mreg_addr), 32'd0);
      check_val("rst_vrf_rdaddr", 32'(vrf_rdaddr), 32'd0);
    end
  endtask

  task automatic idle(input int n, input bit lqr);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, lqr, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Single OPACC a=3 b=4 c=5 mreg 1
    step(1'b1, enc(0, 3, 4, 5, 1), 3'd0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // OPACC mreg0 then COUT mreg0 as soon as possible: hazard stall
    step(1'b1, enc(0, 1, 2, 3, 0), 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    step(1'b1, enc(2, 7, 8, 9, 0), 3'd6, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);

    // COUT with the load queue not ready for 4 cycles
    step(1'b1, enc(2, 10, 11, 12, 1), 3'd5, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(6, 1'b1);

    // Illegal funct3
    step(1'b1, enc(5, 1, 1, 1, 0), 3'd2, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Back-to-back OPACC to the same mreg
    step(1'b1, enc(0, 1, 1, 1, 1), 3'd1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    step(1'b1, enc(0, 2, 2, 2, 1), 3'd1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Flush while a COUT is stalled on the load queue
    step(1'b1, enc(2, 4, 5, 6, 0), 3'd3, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Reset during DRAIN
    step(1'b1, enc(2, 9, 9, 9, 0), 3'd4, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      w = enc($urandom_range(2), $urandom_range(31), $urandom_range(31), $urandom_range(31),
              $urandom_range(NM - 1));
      if ($urandom_range(15) == 0) w[6:0] = 7'($urandom);
      if ($urandom_range(9) == 0) w[14:12] = 3'($urandom);
      w[31:26] = 6'($urandom);
      step(($urandom_range(9) < 7), w, LQW'($urandom), ($urandom_range(9) < 6),
           ($urandom_range(11) == 0), ($urandom_range(299) == 0));
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
